elevator_call_scheduler: RTL and testbench

//   Latches floor-call buttons into a pending-request register and sequences them, one at a time, into the
//   3-floor elevator controller. The controller only accepts a move when exactly one call line is high and

---
 rtl/elevator_pkg.sv | 27 ++
 rtl/scan_target_sel.sv | 55 +++++
 rtl/elevator_call_scheduler.sv | 137 +++++++++++++
 tb/tb_elevator_call_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler: floor count, FSM state
// encoding and one-hot/index conversion helpers.
package elevator_pkg;

    localparam int N_FLOORS = 3;
    localparam int IDX_W    = $clog2(N_FLOORS);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DISPATCH = 3'd1;
    localparam logic [2:0] ST_TRAVEL   = 3'd2;
    localparam logic [2:0] ST_DWELL    = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

    function automatic logic [N_FLOORS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_FLOORS-1:0] oh;
        for (int i = 0; i < N_FLOORS; i++) oh[i] = (IDX_W'(i) == idx);
        return oh;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_FLOORS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_FLOORS; i++) if (oh[i]) idx = IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/scan_target_sel.sv
// Combinational SCAN picker: a request at the current floor wins, otherwise the
// nearest request in the travel direction, otherwise the nearest behind (reversing).
module scan_target_sel
    import elevator_pkg::*;
(
    input  logic [N_FLOORS-1:0] i_pending,
    input  logic [IDX_W-1:0]    i_cur_floor,
    input  logic                i_dir_up,
    output logic [IDX_W-1:0]    o_target,
    output logic                o_new_dir,
    output logic                o_valid,
    output logic                o_here
);

    logic             w_above;
    logic             w_below;
    logic [IDX_W-1:0] w_above_idx;
    logic [IDX_W-1:0] w_below_idx;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        w_above     = 1'b0;
        w_below     = 1'b0;
        w_above_idx = '0;
        w_below_idx = '0;
        // Descending scan leaves the lowest floor above; ascending leaves the highest below.
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (i_pending[i] && (IDX_W'(i) > i_cur_floor)) begin
                w_above     = 1'b1;
                w_above_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (i_pending[i] && (IDX_W'(i) < i_cur_floor)) begin
                w_below     = 1'b1;
                w_below_idx = IDX_W'(i);
            end
        end

        o_valid   = |i_pending;
        o_here    = |(i_pending & idx_to_onehot(i_cur_floor));
        o_target  = i_cur_floor;
        o_new_dir = i_dir_up;
        if (!o_here) begin
            if (i_dir_up) begin
                if (w_above)      o_target = w_above_idx;
                else if (w_below) begin o_target = w_below_idx; o_new_dir = 1'b0; end
            end else begin
                if (w_below)      o_target = w_below_idx;
                else if (w_above) begin o_target = w_above_idx; o_new_dir = 1'b1; end
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls and feeds them one at a time, as a clean one-hot call,
// to the 3-floor elevator controller, with dispatch retry, dwell and sticky fault.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int REQ_HOLD     = 8,
    parameter int DWELL_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] i_btn_call,
    input  logic [N_FLOORS-1:0] i_floor_sens,
    input  logic                i_moving,
    input  logic                i_ctrl_fault,
    input  logic                i_stop_in,
    output logic [N_FLOORS-1:0] o_call_out,
    output logic [N_FLOORS-1:0] o_pending,
    output logic                o_dir_up,
    output logic                o_sched_fault
);

    localparam int CNT_W = $clog2((REQ_HOLD > DWELL_CYCLES) ? REQ_HOLD : DWELL_CYCLES) + 1;

    logic [2:0]          r_state;
    logic [N_FLOORS-1:0] r_pending;
    logic [N_FLOORS-1:0] r_call_out;
    logic                r_dir_up;
    logic [IDX_W-1:0]    r_cur_floor;
    logic [IDX_W-1:0]    r_target;
    logic [CNT_W-1:0]    r_hold_cnt;
    logic [CNT_W-1:0]    r_dwell_cnt;

    logic [2:0]          w_state_nxt;
    logic [N_FLOORS-1:0] w_clr;
    logic [N_FLOORS-1:0] w_set;
    logic [N_FLOORS-1:0] w_cur_oh;
    logic [N_FLOORS-1:0] w_tgt_oh;
    logic [IDX_W-1:0]    w_sel_target;
    logic                w_sel_new_dir;
    logic                w_sel_valid;
    logic                w_sel_here;
    logic                w_sens_bad;

    scan_target_sel u_sel (
        .i_pending   (r_pending),
        .i_cur_floor (r_cur_floor),
        .i_dir_up    (r_dir_up),
        .o_target    (w_sel_target),
        .o_new_dir   (w_sel_new_dir),
        .o_valid     (w_sel_valid),
        .o_here      (w_sel_here)
    );

    assign w_cur_oh   = idx_to_onehot(r_cur_floor);
    assign w_tgt_oh   = idx_to_onehot(r_target);
    assign w_sens_bad = ($countones(i_floor_sens) > 1);
    // A repeat press of the floor being dwelt at is already being served.
    assign w_set      = i_btn_call & ~((r_state == ST_DWELL) ? w_cur_oh : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = '0;
        if (i_ctrl_fault || w_sens_bad) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid && !i_stop_in) begin
                        if (w_sel_here && |(i_floor_sens & w_cur_oh)) begin
                            w_state_nxt = ST_DWELL;
                            w_clr       = w_cur_oh;
                        end else begin
                            w_state_nxt = ST_DISPATCH;
                        end
                    end
                end
                ST_DISPATCH: begin
                    if (i_stop_in)     w_state_nxt = ST_IDLE;
                    else if (i_moving) w_state_nxt = ST_TRAVEL;
                    else if ((r_call_out != '0) && (r_hold_cnt == CNT_W'(REQ_HOLD - 1)))
                        w_state_nxt = ST_IDLE;
                end
                ST_TRAVEL: begin
                    if (|(i_floor_sens & w_tgt_oh) && !i_moving) begin
                        w_state_nxt = ST_DWELL;
                        w_clr       = w_tgt_oh;
                    end
                end
                ST_DWELL: begin
                    if (r_dwell_cnt == CNT_W'(DWELL_CYCLES - 1)) w_state_nxt = ST_IDLE;
                end
                ST_FAULT: w_state_nxt = ST_FAULT;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_call_out  <= '0;
            r_dir_up    <= 1'b1;
            r_cur_floor <= '0;
            r_target    <= '0;
            r_hold_cnt  <= '0;
            r_dwell_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | w_set;

            if ($onehot(i_floor_sens)) r_cur_floor <= onehot_to_idx(i_floor_sens);

            if ((r_state == ST_IDLE) && (w_state_nxt == ST_DISPATCH || w_state_nxt == ST_DWELL)) begin
                r_target <= w_sel_target;
                r_dir_up <= w_sel_new_dir;
            end

            // The call is only driven while the scheduler stays in DISPATCH.
            r_call_out <= '0;
            if ((r_state == ST_DISPATCH) && (w_state_nxt == ST_DISPATCH)) r_call_out <= w_tgt_oh;

            if (r_state != ST_DISPATCH)                      r_hold_cnt <= '0;
            else if ((r_call_out != '0) && (r_hold_cnt != '1)) r_hold_cnt <= r_hold_cnt + 1'b1;

            if (r_state != ST_DWELL)       r_dwell_cnt <= '0;
            else if (r_dwell_cnt != '1)    r_dwell_cnt <= r_dwell_cnt + 1'b1;
        end
    end

    assign o_call_out    = r_call_out;
    assign o_pending     = r_pending;
    assign o_dir_up      = r_dir_up;
    assign o_sched_fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: dispatch, SCAN ordering, retry,
// stop inhibit, dwell handling and sticky fault, with hand-computed expectations.
module tb_elevator_call_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn_call;
    logic [2:0] floor_sens;
    logic       moving;
    logic       ctrl_fault;
    logic       stop_in;
    logic [2:0] call_out;
    logic [2:0] pending;
    logic       dir_up;
    logic       sched_fault;

    int checks = 0;
    int errors = 0;

    elevator_call_scheduler #(.REQ_HOLD(8), .DWELL_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_btn_call    (btn_call),
        .i_floor_sens  (floor_sens),
        .i_moving      (moving),
        .i_ctrl_fault  (ctrl_fault),
        .i_stop_in     (stop_in),
        .o_call_out    (call_out),
        .o_pending     (pending),
        .o_dir_up      (dir_up),
        .o_sched_fault (sched_fault)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; btn_call = '0; floor_sens = 3'b001;
        moving = 1'b0; ctrl_fault = 1'b0; stop_in = 1'b0;
        tick(1);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL reset_call_out got %b exp 000", call_out); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending got %b exp 000", pending); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir_up got %b exp 1", dir_up); end
        checks++; if (sched_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", sched_fault); end
    endtask

    task automatic test_basic();
        btn_call = 3'b100; tick(1); btn_call = '0;
        checks++; if (pending !== 3'b100) begin errors++; $display("FAIL basic_latch got %b exp 100", pending); end
        tick(1);
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL basic_dispatch_entry got %b exp 000", call_out); end
        tick(1);
        checks++; if (call_out !== 3'b100) begin errors++; $display("FAIL basic_call got %b exp 100", call_out); end
        moving = 1'b1; floor_sens = 3'b000; tick(1);
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL basic_travel_call got %b exp 000", call_out); end
        tick(2);
        floor_sens = 3'b100; moving = 1'b0; tick(1);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL basic_served got %b exp 000", pending); end
        tick(16);
    endtask

    task automatic test_scan();
        do_reset();
        btn_call = 3'b110; tick(1); btn_call = '0;
        tick(2);
        checks++; if (call_out !== 3'b010) begin errors++; $display("FAIL scan_first got %b exp 010", call_out); end
        moving = 1'b1; floor_sens = 3'b000; tick(1);
        floor_sens = 3'b010; moving = 1'b0; tick(1);
        checks++; if (pending !== 3'b100) begin errors++; $display("FAIL scan_first_served got %b exp 100", pending); end
        tick(17);
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL scan_dwell_gap got %b exp 000", call_out); end
        tick(1);
        checks++; if (call_out !== 3'b100) begin errors++; $display("FAIL scan_second got %b exp 100", call_out); end
        moving = 1'b1; floor_sens = 3'b000; tick(1);
        floor_sens = 3'b100; moving = 1'b0; tick(1);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL scan_second_served got %b exp 000", pending); end
        btn_call = 3'b001; tick(1); btn_call = '0;
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL scan_press_low got %b exp 001", pending); end
        tick(16);
        checks++; if (dir_up !== 1'b0) begin errors++; $display("FAIL scan_reverse_dir got %b exp 0", dir_up); end
        tick(1);
        checks++; if (call_out !== 3'b001) begin errors++; $display("FAIL scan_down_call got %b exp 001", call_out); end
    endtask

    task automatic test_hold_retry();
        int n;
        do_reset();
        btn_call = 3'b010; tick(1); btn_call = '0;
        tick(2);
        n = 0;
        while (call_out == 3'b010 && n < 20) begin
            n++;
            tick(1);
        end
        checks++; if (n != 8) begin errors++; $display("FAIL hold_length got %0d exp 8", n); end
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL hold_drop got %b exp 000", call_out); end
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL hold_pending_kept got %b exp 010", pending); end
        tick(2);
        checks++; if (call_out !== 3'b010) begin errors++; $display("FAIL hold_retry got %b exp 010", call_out); end
    endtask

    task automatic test_stop();
        stop_in = 1'b1; tick(1);
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL stop_drop got %b exp 000", call_out); end
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL stop_inhibit cycle %0d got %b exp 000", k, call_out); end
        end
        stop_in = 1'b0; tick(2);
        checks++; if (call_out !== 3'b010) begin errors++; $display("FAIL stop_resume got %b exp 010", call_out); end
        checks++; if (pending !== 3'b010) begin errors++; $display("FAIL stop_pending got %b exp 010", pending); end
    endtask

    task automatic test_dwell_ignore();
        int pulses;
        do_reset();
        btn_call = 3'b001; tick(1); btn_call = '0;
        checks++; if (pending !== 3'b001) begin errors++; $display("FAIL here_latch got %b exp 001", pending); end
        tick(1);
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL here_served got %b exp 000", pending); end
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL here_no_call got %b exp 000", call_out); end
        btn_call = 3'b001; tick(1); btn_call = '0;
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL dwell_ignore got %b exp 000", pending); end
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (call_out != 3'b000) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL dwell_no_pulse got %0d exp 0", pulses); end
    endtask

    task automatic test_fault();
        do_reset();
        btn_call = 3'b100; tick(1); btn_call = '0;
        tick(2);
        moving = 1'b1; floor_sens = 3'b000; tick(1);
        floor_sens = 3'b011; tick(1);
        checks++; if (sched_fault !== 1'b1) begin errors++; $display("FAIL fault_sens got %b exp 1", sched_fault); end
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL fault_sens_call got %b exp 000", call_out); end
        floor_sens = 3'b001; moving = 1'b0; btn_call = 3'b010; tick(1); btn_call = '0;
        tick(5);
        checks++; if (sched_fault !== 1'b1) begin errors++; $display("FAIL fault_sticky got %b exp 1", sched_fault); end
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL fault_sticky_call got %b exp 000", call_out); end
        reset = 1'b0; tick(1); reset = 1'b1;
        checks++; if (sched_fault !== 1'b0) begin errors++; $display("FAIL fault_reset got %b exp 0", sched_fault); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL fault_reset_pending got %b exp 000", pending); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL fault_reset_dir got %b exp 1", dir_up); end

        btn_call = 3'b100; tick(1); btn_call = '0;
        tick(2);
        moving = 1'b1; floor_sens = 3'b000; tick(1);
        ctrl_fault = 1'b1; tick(1);
        checks++; if (sched_fault !== 1'b1) begin errors++; $display("FAIL fault_ctrl got %b exp 1", sched_fault); end
        ctrl_fault = 1'b0; tick(3);
        checks++; if (sched_fault !== 1'b1) begin errors++; $display("FAIL fault_ctrl_sticky got %b exp 1", sched_fault); end
        checks++; if (call_out !== 3'b000) begin errors++; $display("FAIL fault_ctrl_call got %b exp 000", call_out); end
        do_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_scan();
        test_hold_retry();
        test_stop();
        test_dwell_ignore();
        test_fault();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
